rgb565_grayscale_ci: RTL and testbench
======================================

# rgb565_grayscale_ci

Multi-cycle OpenRISC custom-instruction unit that converts four packed RGB565 pixels (two in `valueA`, two in `valueB`) into four 8-bit luminance bytes packed in `result`. Channel weights and throughput (pixels converted per clock) are parameters, and arithmetic uses full-precision channel expansion with saturation. It sits on the CPU custom-instruction bus beside the other CI units. Its result is OR-combined with theirs, so it drives zero whenever it is not signalling `done`.

## Interface
- `customInstructionId`, 8'd0: `iseId` value this unit responds to.
- `PIXELS_PER_CYCLE`, 1: pixels converted per clock; legal values 1, 2, 4. Any other value is an elaboration error.
- `WEIGHT_R`, 8'd54: red weight, in units of 1/256.
- `WEIGHT_G`, 8'd183: green weight, in units of 1/256.
- `WEIGHT_B`, 8'd19: blue weight, in units of 1/256.

Ports:
- `clock`, in, 1: single clock; all state is updated on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: CI start strobe, one cycle wide.
- `iseId`, in, 8: CI selector.
- `valueA`, in, 32: pixel 0 in `[15:0]`, pixel 1 in `[31:16]`.
- `valueB`, in, 32: pixel 2 in `[15:0]`, pixel 3 in `[31:16]`.
- `done`, out, 1: one-cycle pulse; `result` is valid only in that cycle.
- `result`, out, 32: gray byte k in `[8k+7:8k]` for pixel k; 32'd0 whenever `done`=0.

## Operation
- States: IDLE, CONVERT, DONE.
- IDLE:
  - When `start`=1 and `iseId`==`customInstructionId`, latch `valueA`/`valueB` into a 64-bit pixel register, clear the accumulator and the pixel counter, and go to CONVERT.
  - Otherwise stay in IDLE.
- CONVERT:
  - Each cycle, convert pixels `cnt` .. `cnt+PIXELS_PER_CYCLE-1`, write their bytes into the result accumulator, and advance `cnt` by `PIXELS_PER_CYCLE`.
  - When the last pixel (index 3) has been converted this cycle, go to DONE.
- DONE: `done`=1, `result` = accumulator; go to IDLE on the next edge.
- A `start` in CONVERT or DONE, for any `iseId`, is ignored. It is not queued and does not disturb the operation in flight.
- A `start` with a non-matching `iseId` is always ignored.
- Per-pixel arithmetic:
  - Expand channels: r8 = {r5, r5[4:2]}, g8 = {g6, g6[5:4]}, b8 = {b5, b5[4:2]}.
  - sum (18 bit) = WEIGHT_R·r8 + WEIGHT_G·g8 + WEIGHT_B·b8 (each product 16 bit, unsigned).
  - gray = sum >> 8 (truncating). If that exceeds 255 (only possible when the weights sum to more than 256), the output is 8'hFF.
- `done` and `result` are driven from registers, never combinationally from the inputs.
- Reset, including an assertion mid-operation:
  - State goes to IDLE immediately.
  - `done`=0, `result`=0, counter and accumulator cleared.
  - Any in-flight instruction is abandoned with no `done` pulse.

## Timing
- Let N = 4 / `PIXELS_PER_CYCLE` (4, 2 or 1).
- `start` is sampled at edge 0. CONVERT occupies the cycles after edges 0 .. N-1. `done`=1 in the cycle after edge N.
- Latency from the `start` cycle to the `done` cycle is N+1 clocks: 5, 3 or 2.
- `done` is high for exactly one cycle per accepted instruction.
- A back-to-back `start` arriving in the `done` cycle is ignored: the unit is still in DONE.
- The earliest accepted follow-up `start` is the cycle after `done`.
- `valueA`/`valueB` need to be stable only in the `start` cycle.
- Reset values: `done`=0, `result`=32'h0, state IDLE.

## Test plan
- Default parameters, `PIXELS_PER_CYCLE`=1:
  - Stimulus: `valueA`=32'hF800_FFFF, `valueB`=32'h001F_07E0, matching id.
  - Required: `done` exactly 5 cycles after `start`, `result`=32'h12B6_35FF (bytes 255, 53, 182, 18).
  - Required: `result`=0 in every other cycle.
- `PIXELS_PER_CYCLE`=4, all-zero pixels:
  - Required: `done` 2 cycles after `start`, `result`=32'h0.
- Id filtering and busy rejection:
  - Required: a `start` with `iseId`≠`customInstructionId` produces no `done`.
  - Stimulus: a second matching `start` issued 2 cycles into CONVERT.
  - Required: the second `start` is ignored, exactly one `done` is produced, and `result` matches the first operands.
- Saturation:
  - Stimulus: `WEIGHT_R`=`WEIGHT_G`=`WEIGHT_B`=8'd200, all pixels 16'hFFFF.
  - Required: `result`=32'hFFFF_FFFF.
- Reset mid-operation:
  - Stimulus: assert `reset` asynchronously (between edges) 2 cycles after `start` with `PIXELS_PER_CYCLE`=1.
  - Required: `done`/`result` go to 0 without waiting for a clock edge, and no `done` pulse follows.
  - Required: a new `start` after reset release completes normally with correct bytes.
- Back-to-back instructions, `PIXELS_PER_CYCLE`=2:
  - Stimulus: issue `start` in the cycle after `done`.
  - Required: the second `done` arrives 3 cycles later with its own correct result.
  - Required: a random 1000-instruction run matches a reference model bit-exactly.

Source files
------------

// File: rtl/rgb565_grayscale_ci.sv
// Custom-instruction unit: converts four packed RGB565 pixels to 8-bit luminance.
// Result bus is zero outside the single done cycle so it can be OR-combined.
module rgb565_grayscale_ci #(
    parameter logic [7:0]  customInstructionId = 8'd0,
    parameter int unsigned PIXELS_PER_CYCLE    = 1,
    parameter logic [7:0]  WEIGHT_R            = 8'd54,
    parameter logic [7:0]  WEIGHT_G            = 8'd183,
    parameter logic [7:0]  WEIGHT_B            = 8'd19
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  iseId,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    localparam int unsigned NUM_PIX   = 4;
    localparam int unsigned PIX_W     = 16;
    localparam int unsigned GRAY_W    = 8;
    localparam int unsigned CNT_W     = 2;
    localparam int unsigned SUM_W     = 18;
    localparam int unsigned PROD_W    = 16;
    localparam int unsigned PIX_REG_W = NUM_PIX * PIX_W;
    localparam int unsigned RES_W     = NUM_PIX * GRAY_W;

    if (!(PIXELS_PER_CYCLE == 1 || PIXELS_PER_CYCLE == 2 || PIXELS_PER_CYCLE == 4)) begin : g_bad_ppc
        $error("PIXELS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PIX_REG_W-1:0]   pix_q, pix_d;
    logic [RES_W-1:0]       acc_q, acc_d;
    logic                   done_d;
    logic [RES_W-1:0]       result_d;
    logic [CNT_W-1:0]       idx_c;
    logic                   last_c;

    // Full-precision channel expansion, weighted sum, saturate above 255.
    function automatic logic [GRAY_W-1:0] to_gray(input logic [PIX_W-1:0] px);
        logic [7:0]        r8, g8, b8;
        logic [PROD_W-1:0] pr, pg, pb;
        logic [SUM_W-1:0]  sum;
        r8  = {px[15:11], px[15:13]};
        g8  = {px[10:5], px[10:9]};
        b8  = {px[4:0], px[4:2]};
        pr  = PROD_W'(WEIGHT_R) * PROD_W'(r8);
        pg  = PROD_W'(WEIGHT_G) * PROD_W'(g8);
        pb  = PROD_W'(WEIGHT_B) * PROD_W'(b8);
        sum = SUM_W'(pr) + SUM_W'(pg) + SUM_W'(pb);
        return (sum[17:16] != 2'b00) ? 8'hFF : sum[15:8];
    endfunction

    assign last_c = (3'(cnt_q) + 3'(PIXELS_PER_CYCLE)) == 3'(NUM_PIX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pix_q   <= '0;
            acc_q   <= '0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pix_q   <= pix_d;
            acc_q   <= acc_d;
            done    <= done_d;
            result  <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pix_d    = pix_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        result_d = '0;
        idx_c    = '0;
        case (state_q)
            IDLE: begin
                if (start && (iseId == customInstructionId)) begin
                    pix_d   = {valueB, valueA};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                // cnt is always a multiple of PIXELS_PER_CYCLE, so cnt+j never wraps
                for (int unsigned j = 0; j < PIXELS_PER_CYCLE; j++) begin
                    idx_c = cnt_q + CNT_W'(j);
                    acc_d[GRAY_W*idx_c +: GRAY_W] = to_gray(pix_q[PIX_W*idx_c +: PIX_W]);
                end
                cnt_d = cnt_q + CNT_W'(PIXELS_PER_CYCLE);
                if (last_c) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = acc_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rgb565_grayscale_ci.sv
// Directed and reference-model checks for rgb565_grayscale_ci across
// several parameterisations sharing one stimulus bus.
module tb_rgb565_grayscale_ci;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  iseId;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic [3:0]  done_v;
    logic [31:0] res_v [4];

    int checks = 0;
    int errors = 0;

    localparam int P1 = 0;   // PIXELS_PER_CYCLE=1, default weights
    localparam int P4 = 1;   // PIXELS_PER_CYCLE=4
    localparam int PS = 2;   // saturating weights
    localparam int P2 = 3;   // PIXELS_PER_CYCLE=2

    rgb565_grayscale_ci #(.customInstructionId(8'd0), .PIXELS_PER_CYCLE(1)) u_p1 (
        .clock(clock), .reset(reset), .start(start), .iseId(iseId),
        .valueA(valueA), .valueB(valueB), .done(done_v[0]), .result(res_v[0]));

    rgb565_grayscale_ci #(.customInstructionId(8'd0), .PIXELS_PER_CYCLE(4)) u_p4 (
        .clock(clock), .reset(reset), .start(start), .iseId(iseId),
        .valueA(valueA), .valueB(valueB), .done(done_v[1]), .result(res_v[1]));

    rgb565_grayscale_ci #(.customInstructionId(8'd0), .PIXELS_PER_CYCLE(1),
                          .WEIGHT_R(8'd200), .WEIGHT_G(8'd200), .WEIGHT_B(8'd200)) u_sat (
        .clock(clock), .reset(reset), .start(start), .iseId(iseId),
        .valueA(valueA), .valueB(valueB), .done(done_v[2]), .result(res_v[2]));

    rgb565_grayscale_ci #(.customInstructionId(8'd0), .PIXELS_PER_CYCLE(2)) u_p2 (
        .clock(clock), .reset(reset), .start(start), .iseId(iseId),
        .valueA(valueA), .valueB(valueB), .done(done_v[3]), .result(res_v[3]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_gray(input logic [15:0] p, input int wr, input int wg, input int wb);
        int r5, g6, b5, r8, g8, b8, s;
        r5 = int'(p[15:11]);
        g6 = int'(p[10:5]);
        b5 = int'(p[4:0]);
        r8 = r5 * 8 + r5 / 4;
        g8 = g6 * 4 + g6 / 16;
        b8 = b5 * 8 + b5 / 4;
        s  = (wr * r8 + wg * g8 + wb * b8) / 256;
        if (s > 255) s = 255;
        return 8'(s);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input logic [31:0] b);
        return {ref_gray(b[31:16], 54, 183, 19), ref_gray(b[15:0], 54, 183, 19),
                ref_gray(a[31:16], 54, 183, 19), ref_gray(a[15:0], 54, 183, 19)};
    endfunction

    // Called right after a falling edge; returns at the next falling edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [7:0] id);
        start  = 1'b1;
        iseId  = id;
        valueA = a;
        valueB = b;
        @(negedge clock);
        start  = 1'b0;
        valueA = $urandom;
        valueB = $urandom;
    endtask

    // Bounded wait for done; returns in the cycle after done.
    task automatic wait_done(input int k, input int exp_lat, input logic [31:0] exp_res, input string tag);
        int lat  = 1;
        bit seen = 1'b0;
        while (lat <= 16 && !seen) begin
            if (done_v[k]) seen = 1'b1;
            else begin
                check({tag, "_res_idle"}, res_v[k], 32'h0);
                @(negedge clock);
                lat++;
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, res_v[k], exp_res);
        @(negedge clock);
        check({tag, "_done_clr"}, 32'(done_v[k]), 32'd0);
        check({tag, "_res_clr"}, res_v[k], 32'h0);
    endtask

    task automatic settle();
        repeat (8) @(negedge clock);
    endtask

    initial begin
        int n_done;
        int lat;
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] b;

        reset  = 1'b1;
        start  = 1'b0;
        iseId  = 8'd0;
        valueA = '0;
        valueB = '0;
        repeat (2) @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            check("rst_done", 32'(done_v[k]), 32'd0);
            check("rst_res", res_v[k], 32'h0);
        end
        reset = 1'b0;
        settle();

        // Primary colours and white through the default weights
        issue(32'hF800_FFFF, 32'h001F_07E0, 8'd0);
        wait_done(P1, 5, 32'h12B6_35FF, "ppc1");
        settle();

        issue(32'h0000_0000, 32'h0000_0000, 8'd0);
        wait_done(P4, 2, 32'h0000_0000, "ppc4_zero");
        settle();
        issue(32'hF800_FFFF, 32'h001F_07E0, 8'd0);
        wait_done(P4, 2, 32'h12B6_35FF, "ppc4_rgb");
        settle();

        // Non-matching id must not start any unit
        issue(32'hF800_FFFF, 32'h001F_07E0, 8'h03);
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            if (|done_v) n_done++;
            @(negedge clock);
        end
        check("bad_id_no_done", 32'(n_done), 32'd0);
        settle();

        // Second matching start two cycles into CONVERT is dropped
        start  = 1'b1;
        iseId  = 8'd0;
        valueA = 32'hFFFF_0000;
        valueB = 32'h07E0_F800;
        n_done = 0;
        lat    = 0;
        r      = '0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clock);
            start = (c == 2);
            if (c == 2) begin
                valueA = 32'h0;
                valueB = 32'h0;
            end
            if (done_v[P1]) begin
                n_done++;
                lat = c;
                r   = res_v[P1];
            end
        end
        check("busy_done_cnt", 32'(n_done), 32'd1);
        check("busy_lat", 32'(lat), 32'd5);
        check("busy_res", r, 32'hB635_FF00);
        settle();

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0);
        wait_done(PS, 5, 32'hFFFF_FFFF, "sat");
        settle();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0);
        wait_done(P1, 5, 32'hFFFF_FFFF, "white_nosat");
        settle();

        // Asynchronous reset while u_p4 shows done and u_p1 is converting
        issue(32'hF800_FFFF, 32'h001F_07E0, 8'd0);
        @(negedge clock);
        check("arst_pre_done", 32'(done_v[P4]), 32'd1);
        check("arst_pre_res", res_v[P4], 32'h12B6_35FF);
        #2 reset = 1'b1;
        #1;
        check("arst_done", 32'(done_v[P4]), 32'd0);
        check("arst_res", res_v[P4], 32'h0);
        @(negedge clock);
        reset  = 1'b0;
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            if (|done_v) n_done++;
            @(negedge clock);
        end
        check("arst_no_done", 32'(n_done), 32'd0);
        issue(32'hF800_FFFF, 32'h001F_07E0, 8'd0);
        wait_done(P1, 5, 32'h12B6_35FF, "post_rst");
        settle();

        // Back-to-back on the two-pixel-per-cycle unit
        issue(32'hF800_FFFF, 32'h001F_07E0, 8'd0);
        wait_done(P2, 3, 32'h12B6_35FF, "b2b_first");
        issue(32'hFFFF_0000, 32'h07E0_F800, 8'd0);
        wait_done(P2, 3, 32'hB635_FF00, "b2b_second");

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            issue(a, b, 8'd0);
            wait_done(P2, 3, ref_word(a, b), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
